uart_byte_io: RTL and testbench
===============================

// Module: uart_byte_io
// PURPOSE
//  Byte-level UART unit serving the core's SENDB/RECVB instructions; sits directly downstream of maindec.
//  Consumes uart_go/rors from the control FSM and the byte to send; drives txd.
//  Samples rxd continuously into a small RX FIFO. Returns uart_done and the received byte for register writeback.
// PARAMETERS
//  CLK_PER_BIT    868  clock cycles per UART bit (100 MHz / 115200); must be >= 4
//  RX_FIFO_DEPTH  8    RX FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1  core clock; the only clock
//  rstn       in   1  synchronous active-low reset, sampled on posedge clk
//  uart_go    in   1  1-cycle request pulse from maindec (SENDB_GO / RECVB_GO)
//  rors       in   1  qualifies uart_go: 1 = send (SENDB), 0 = receive (RECVB)
//  tdata      in   8  byte to transmit (rs2[7:0]); sampled on the uart_go cycle only
//  rdata      out  8  received byte; valid from uart_done until the next receive request
//  uart_done  out  1  1-cycle completion pulse for the current request
//  rx_overrun out  1  sticky: a frame arrived while the RX FIFO was full; cleared only by reset
//  txd        out  1  serial out, idle high
//  rxd        in   1  serial in, asynchronous
// BEHAVIOUR
//  Reset values: txd=1, uart_done=0, rdata=8'h00, rx_overrun=0; FIFO empty; all FSMs idle.
//  Reset mid-frame aborts the frame; txd is 1 on the cycle after rstn is sampled low.
//  Request FSM (REQ_IDLE, REQ_TX, REQ_RX):
//   - IDLE: go&rors -> latch tdata, start TX, go to REQ_TX. go&~rors -> REQ_RX.
//   - REQ_TX: uart_done pulses on the cycle the stop bit's final count expires; then IDLE.
//   - REQ_RX: if FIFO non-empty, pop into rdata and pulse uart_done the same cycle; then IDLE.
//     If the FIFO is empty, wait; a byte pushed on cycle N is popped and done on cycle N+1.
//   - go outside IDLE is ignored (maindec never issues it). uart_done is never high two consecutive cycles.
//  TX: frame is start(0), d0..d7 LSB first, stop(1); each bit lasts exactly CLK_PER_BIT cycles.
//   - txd goes 0 on the cycle after the uart_go cycle; total frame 10*CLK_PER_BIT cycles.
//   - uart_done lands on the last stop-bit cycle, so the line is idle before the next SENDB.
//  RX, free-running and independent of requests:
//   - rxd passes a 2-flop synchroniser. A falling edge in RX_IDLE -> RX_START.
//   - RX_START: at CLK_PER_BIT/2, recheck; if 1, false start -> RX_IDLE.
//   - Data bits: sample every CLK_PER_BIT from the mid-start point, shifting in LSB first.
//   - RX_STOP: at mid-stop, push the byte if the stop bit is 1; a framing error discards the byte.
//     Return to RX_IDLE, re-armed for a start edge.
//  FIFO: push and pop in the same cycle are both honoured. Count stays constant; empty->push+pop is not
//   possible because a pop requires non-empty, so a byte is never bypassed. Push when full: byte dropped,
//   rx_overrun set. Pointers wrap modulo RX_FIFO_DEPTH.
//  Counters: baud counter width $clog2(CLK_PER_BIT); bit index 0..7; there is no shared baud tick
//   between TX and RX.
// STRUCTURE
//  uart_pkg: req_state_t, tx_state_t, rx_state_t enums, and the default CLK_PER_BIT constant.
//  Sub-module uart_rx_fifo (DEPTH param; push/din, pop/dout, empty, full) instantiated once.
//  TX, RX and request FSMs stay in this file; maindec connection is by port name.
// TESTING (CLK_PER_BIT=8 unless noted)
//  1 Reset: hold rstn=0 for 3 cycles mid-TX frame -> txd=1, uart_done=0, rdata=00 next cycle.
//  2 Send: go=1, rors=1, tdata=8'hA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
//     uart_done is a single pulse at cycle 80.
//  3 Recv, FIFO empty: go, rors=0; then drive frame 8'h3C on rxd -> one uart_done pulse.
//     rdata=3C is held until the next go.
//  4 Recv, data preloaded: drive 8'h11 and 8'h22 first; two RECVB requests -> done on the cycle after
//     each go; rdata 11 then 22.
//  5 Overrun with DEPTH=2: drive 3 frames (01, 02, 03) with no pops -> rx_overrun=1; pops return 01, 02.
//  6 Glitch/framing: 2-cycle low pulse on rxd -> no push. Frame with stop=0 -> no push, no overrun.
//     A subsequent valid 8'h7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the byte-level UART unit.
package uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT   = 868;  // 100 MHz / 115200
  localparam int DEFAULT_RX_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {REQ_IDLE, REQ_TX, REQ_RX} req_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes until a RECVB request pops them.
// A push and a pop in the same cycle are both honoured, including when the FIFO is full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_RX_FIFO_DEPTH,  // power of two, >= 2
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array is deliberately left out of reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_byte_io.sv
// Byte-level UART serving SENDB/RECVB: request FSM, 8N1 transmitter, free-running receiver
// feeding an RX FIFO. TX and RX each own their baud counter; there is no shared tick.
module uart_byte_io
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT   = DEFAULT_CLK_PER_BIT,    // >= 4
  parameter int RX_FIFO_DEPTH = DEFAULT_RX_FIFO_DEPTH   // power of two, >= 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_go,
  input  logic       rors,
  input  logic [7:0] tdata,
  output logic [7:0] rdata,
  output logic       uart_done,
  output logic       rx_overrun,
  output logic       txd,
  input  logic       rxd
);

  localparam int              CW        = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]   BAUD_DONE = CW'(CLK_PER_BIT - 2);
  localparam logic [CW-1:0]   BAUD_HALF = CW'(CLK_PER_BIT / 2 - 1);

  req_state_t    req_state;
  tx_state_t     tx_state;
  rx_state_t     rx_state;

  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_done_q;
  logic          tx_start;
  logic          tx_last;

  logic          rxd_s1, rxd_s2, rxd_s3;
  logic          rx_fall;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_push;
  logic          rx_pop;

  logic [7:0]    rdata_q;
  logic [7:0]    fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;

  assign tx_start  = (req_state == REQ_IDLE) && uart_go && rors;
  assign tx_last   = (tx_state == TX_STOP) && (tx_cnt == BAUD_LAST);
  assign rx_fall   = rxd_s3 && !rxd_s2;
  assign rx_push   = (rx_state == RX_STOP) && (rx_cnt == BAUD_LAST) && rxd_s2;
  assign rx_pop    = (req_state == REQ_RX) && !fifo_empty;

  // The popped byte is presented on the done cycle itself, then held until the next pop.
  assign uart_done = tx_done_q || rx_pop;
  assign rdata     = rx_pop ? fifo_dout : rdata_q;

  // Request FSM: dispatches SENDB/RECVB and holds the last received byte.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      req_state <= REQ_IDLE;
      rdata_q   <= 8'h00;
    end else begin
      case (req_state)
        REQ_IDLE: if (uart_go) req_state <= rors ? REQ_TX : REQ_RX;
        REQ_TX:   if (tx_last) req_state <= REQ_IDLE;
        REQ_RX: begin
          if (rx_pop) begin
            rdata_q   <= fifo_dout;
            req_state <= REQ_IDLE;
          end
        end
        default:  req_state <= REQ_IDLE;
      endcase
    end
  end

  // Transmitter: start, 8 data bits LSB first, stop; done lands on the final stop-bit cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      txd       <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_start) begin
            tx_shift <= tdata;
            tx_cnt   <= '0;
            txd      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              txd      <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          // Registered done must be set one count early to appear on the last stop cycle.
          if (tx_cnt == BAUD_DONE) tx_done_q <= 1'b1;
          if (tx_cnt == BAUD_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser on rxd plus one extra stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_s3 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
    end
  end

  // Receiver: mid-bit sampling anchored on the mid-start point; bad stop bits drop the byte.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == BAUD_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Sticky overrun: a good frame found no room (a same-cycle pop makes room).
  always_ff @(posedge clk) begin
    if (!rstn) rx_overrun <= 1'b0;
    else if (rx_push && fifo_full && !rx_pop) rx_overrun <= 1'b1;
  end

  uart_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push),
    .din   (rx_shift),
    .pop   (rx_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_uart_byte_io.sv
// Self-checking bench for uart_byte_io with CLK_PER_BIT=8: TX frames from a vector table,
// RX bytes tracked by a scoreboard queue, plus reset, overrun and glitch/framing sequences.
module tb_uart_byte_io;

  localparam int CPB = 8;

  logic       clk;
  logic       rstn;
  logic       uart_go, rors;
  logic [7:0] tdata;
  logic [7:0] rdata;
  logic       uart_done, rx_overrun, txd, rxd;

  logic       go2, rxd2;
  logic [7:0] rdata2;
  logic       done2, ovr2, txd2;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       rx_pending = 1'b0;
  int         rx_done_cnt = 0;
  logic       prev_done = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // frame[0] is the first bit on the line
  } tx_vec_t;

  tx_vec_t tx_vecs [4];

  uart_byte_io #(.CLK_PER_BIT(CPB), .RX_FIFO_DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .uart_go(uart_go), .rors(rors), .tdata(tdata),
    .rdata(rdata), .uart_done(uart_done), .rx_overrun(rx_overrun), .txd(txd), .rxd(rxd)
  );

  uart_byte_io #(.CLK_PER_BIT(CPB), .RX_FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rstn(rstn), .uart_go(go2), .rors(rors), .tdata(tdata),
    .rdata(rdata2), .uart_done(done2), .rx_overrun(ovr2), .txd(txd2), .rxd(rxd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Advance to just after the n-th next rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit on2, input logic v);
    if (on2) rxd2 = v;
    else     rxd  = v;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input bit on2);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_line(on2, f[i]);
      tick(CPB);
    end
    set_line(on2, 1'b1);
  endtask

  task automatic issue_recv();
    rx_pending = 1'b1;
    uart_go    = 1'b1;
    rors       = 1'b0;
    tick(1);
    uart_go    = 1'b0;
  endtask

  task automatic wait_rx_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (rx_done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(rx_done_cnt >= target), 1);
  endtask

  // Scoreboard monitor: every RECVB completion pops the next expected byte.
  always @(negedge clk) begin
    if (rstn && uart_done) begin
      check("done_single_cycle", {31'b0, prev_done}, 0);
      if (rx_pending) begin
        rx_pending = 1'b0;
        rx_done_cnt++;
        check("rx_byte_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("rx_rdata", {24'b0, rdata}, {24'b0, exp_q.pop_front()});
      end
    end
    prev_done = uart_done;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tx_vecs[0] = '{data: 8'hA5, frame: 10'b1_10100101_0};
    tx_vecs[1] = '{data: 8'h00, frame: 10'b1_00000000_0};
    tx_vecs[2] = '{data: 8'hFF, frame: 10'b1_11111111_0};
    tx_vecs[3] = '{data: 8'h5A, frame: 10'b1_01011010_0};

    rstn = 1'b0; uart_go = 1'b0; go2 = 1'b0; rors = 1'b0; tdata = 8'h00;
    rxd = 1'b1; rxd2 = 1'b1;
    tick(3);
    @(negedge clk);
    check("reset_txd", {31'b0, txd}, 1);
    check("reset_done", {31'b0, uart_done}, 0);
    check("reset_rdata", {24'b0, rdata}, 0);
    check("reset_overrun", {31'b0, rx_overrun}, 0);
    tick(1);
    rstn = 1'b1;
    tick(2);

    // SENDB frames: bit-by-bit txd and a single done on cycle 80 after the go cycle.
    for (int v = 0; v < 4; v++) begin
      uart_go = 1'b1; rors = 1'b1; tdata = tx_vecs[v].data;
      tick(1);
      uart_go = 1'b0; tdata = ~tx_vecs[v].data;
      for (int c = 1; c <= 82; c++) begin
        @(negedge clk);
        if (c <= 80) check($sformatf("tx%0d_txd_c%0d", v, c), {31'b0, txd},
                           {31'b0, tx_vecs[v].frame[(c - 1) / CPB]});
        else         check($sformatf("tx%0d_idle_c%0d", v, c), {31'b0, txd}, 1);
        check($sformatf("tx%0d_done_c%0d", v, c), {31'b0, uart_done}, {31'b0, c == 80});
      end
      tick(1);
    end

    // RECVB with an empty FIFO, then the byte arrives.
    issue_recv();
    tick(3);
    exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1, 1'b0);
    wait_rx_done(1, 40, "recv_empty_done");
    tick(20);
    @(negedge clk);
    check("recv_empty_rdata_held", {24'b0, rdata}, 8'h3C);
    check("recv_empty_no_extra_done", {31'b0, uart_done}, 0);

    // Reset in the middle of a TX frame.
    tick(1);
    uart_go = 1'b1; rors = 1'b1; tdata = 8'h00;
    tick(1);
    uart_go = 1'b0;
    tick(30);
    rstn = 1'b0;
    tick(1);
    @(negedge clk);
    check("midframe_reset_txd", {31'b0, txd}, 1);
    check("midframe_reset_done", {31'b0, uart_done}, 0);
    check("midframe_reset_rdata", {24'b0, rdata}, 0);
    tick(2);
    rstn = 1'b1;
    tick(20);
    @(negedge clk);
    check("after_reset_txd_idle", {31'b0, txd}, 1);

    // Preloaded FIFO: done on the cycle right after each go.
    tick(1);
    exp_q.push_back(8'h11); send_rx(8'h11, 1'b1, 1'b0);
    exp_q.push_back(8'h22); send_rx(8'h22, 1'b1, 1'b0);
    tick(4);
    issue_recv();
    @(negedge clk);
    check("recv_pre1_done", {31'b0, uart_done}, 1);
    tick(3);
    issue_recv();
    @(negedge clk);
    check("recv_pre2_done", {31'b0, uart_done}, 1);
    tick(10);
    @(negedge clk);
    check("recv_pre2_rdata_held", {24'b0, rdata}, 8'h22);
    check("recv_count", rx_done_cnt, 3);

    // Glitch and framing error are discarded; the following good byte is intact.
    tick(1);
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(40);
    send_rx(8'h55, 1'b0, 1'b0);
    tick(20);
    @(negedge clk);
    check("framing_no_overrun", {31'b0, rx_overrun}, 0);
    tick(1);
    exp_q.push_back(8'h7E);
    send_rx(8'h7E, 1'b1, 1'b0);
    tick(5);
    issue_recv();
    @(negedge clk);
    check("after_glitch_done", {31'b0, uart_done}, 1);
    check("after_glitch_rdata", {24'b0, rdata}, 8'h7E);
    tick(3);
    check("scoreboard_drained", exp_q.size(), 0);

    // Overrun on the depth-2 instance.
    send_rx(8'h01, 1'b1, 1'b1);
    send_rx(8'h02, 1'b1, 1'b1);
    tick(5);
    @(negedge clk);
    check("ovr_before_third", {31'b0, ovr2}, 0);
    tick(1);
    send_rx(8'h03, 1'b1, 1'b1);
    tick(5);
    @(negedge clk);
    check("ovr_after_third", {31'b0, ovr2}, 1);
    tick(1);
    go2 = 1'b1; rors = 1'b0;
    tick(1);
    go2 = 1'b0;
    @(negedge clk);
    check("ovr_pop1_done", {31'b0, done2}, 1);
    check("ovr_pop1_rdata", {24'b0, rdata2}, 8'h01);
    tick(3);
    go2 = 1'b1;
    tick(1);
    go2 = 1'b0;
    @(negedge clk);
    check("ovr_pop2_done", {31'b0, done2}, 1);
    check("ovr_pop2_rdata", {24'b0, rdata2}, 8'h02);
    tick(2);
    @(negedge clk);
    check("ovr_sticky", {31'b0, ovr2}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
